jk_mod_counter: RTL and testbench

// - Synchronous modulo-N up/down counter whose state bits are JK flip-flop cells, one per bit.
// - Downstream consumer of the JK flip-flop stage: it instantiates JK cells and derives every

---
 rtl/jk_mod_counter_pkg.sv | 26 ++
 rtl/jk_mod_counter_jk_cell.sv | 43 ++++
 rtl/jk_mod_counter.sv | 141 ++++++++++++++
 tb/tb_jk_mod_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/jk_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_pkg
// Shared definitions for the JK-cell based modulo counter.
//   - JK_* : two-bit {J,K} codes understood by jk_cell
//   - jk_force() : returns the {J,K} code that drives a cell to a given bit
//     value in one edge, regardless of its present state
// -----------------------------------------------------------------------------
package jk_mod_counter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Set/clear code that lands a cell on value b independent of its current Q.
    function automatic logic [1:0] jk_force(input logic b);
        logic [1:0] code;
        if (b) begin
            code = JK_SET;
        end else begin
            code = JK_CLR;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// One JK flip-flop with synchronous active-high reset to Q=0.
// Ports:
//   clk  in  clock, state changes on rising edge
//   rst  in  synchronous active-high reset (Q=0)
//   j    in  J input
//   k    in  K input
//   q    out registered state
//   qn   out complement of q
// -----------------------------------------------------------------------------
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic r_q;

    // JK state update: hold / clear / set / toggle, reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: r_q <= r_q;
                JK_CLR:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TOG:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
// Synchronous modulo-MODULUS up/down counter built from WIDTH JK cells.
// Every state bit is a jk_cell; this level only generates the J/K pairs,
// decodes terminal count and registers the wrap pulse.
// Parameters:
//   WIDTH    number of state bits / JK cells
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (q=0, wrap=0)
//   en    in   count enable
//   up    in   1 = increment, 0 = decrement
//   load  in   synchronous parallel load (out-of-range value loads 0)
//   d     in   parallel load value
//   q     out  current count (Q of each JK cell)
//   tc    out  combinational terminal count, look-ahead of a wrap
//   wrap  out  registered pulse, high for the cycle following a wrap edge
// -----------------------------------------------------------------------------
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Top count value, truncated to WIDTH bits so MODULUS=2**WIDTH works.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_up_mask;
    logic [WIDTH-1:0] w_dn_mask;
    logic             w_run_up;
    logic             w_run_dn;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_oor;
    logic             w_wrap_next;
    logic             r_wrap;

    assign w_at_max   = (q == MAX);
    assign w_at_zero  = (q == {WIDTH{1'b0}});
    // d > MAX is the same as d >= MODULUS but stays within WIDTH bits.
    assign w_load_oor = (d > MAX);

    // Toggle masks: a bit toggles up when all lower bits are 1, down when all
    // lower bits are 0 (read from the cells' QN outputs).
    always_comb begin
        w_up_mask = {WIDTH{1'b0}};
        w_dn_mask = {WIDTH{1'b0}};
        w_run_up  = 1'b1;
        w_run_dn  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_mask[i] = w_run_up;
            w_dn_mask[i] = w_run_dn;
            w_run_up     = w_run_up & q[i];
            w_run_dn     = w_run_dn & w_qn[i];
        end
    end

    // Next J/K selection: load > count (wrap or toggle) > hold.
    always_comb begin
        w_j         = {WIDTH{1'b0}};
        w_k         = {WIDTH{1'b0}};
        w_wrap_next = 1'b0;
        if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_load_oor) begin
                    {w_j[i], w_k[i]} = JK_CLR;
                end else begin
                    {w_j[i], w_k[i]} = jk_force(d[i]);
                end
            end
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    // Wrap to 0 by clearing every bit directly.
                    w_wrap_next = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        {w_j[i], w_k[i]} = JK_CLR;
                    end
                end else begin
                    w_j = w_up_mask;
                    w_k = w_up_mask;
                end
            end else begin
                if (w_at_zero) begin
                    // Wrap to MAX by forcing each bit to its target value.
                    w_wrap_next = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        {w_j[i], w_k[i]} = jk_force(MAX[i]);
                    end
                end else begin
                    w_j = w_dn_mask;
                    w_k = w_dn_mask;
                end
            end
        end else begin
            w_j = {WIDTH{1'b0}};
            w_k = {WIDTH{1'b0}};
        end
    end

    // State bits: one JK cell per bit.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (w_j[g]),
            .k   (w_k[g]),
            .q   (q[g]),
            .qn  (w_qn[g])
        );
    end

    assign tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

    // Wrap pulse register: captures the wrap decision of the current edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_counter
// Directed bench for jk_mod_counter: a vector table for the WIDTH=4 /
// MODULUS=10 instance and a hand-written sequence for a WIDTH=3 / MODULUS=8
// full-range instance, including per-cycle J/K checks.
// -----------------------------------------------------------------------------
module tb_jk_mod_counter;

    logic       clk;
    logic       rst, en, up, load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap;

    logic       rst8, en8, up8, load8;
    logic [2:0] d8;
    logic [2:0] q8;
    logic       tc8, wrap8;

    int checks = 0;
    int errors = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .d(d8),
        .q(q8), .tc(tc8), .wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] d;
        logic       tc;    // expected before the edge
        logic [3:0] q;     // expected after the edge
        logic       wrap;  // expected after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] dv, input logic t, input logic [3:0] qe,
                       input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.load = l; v.d = dv;
        v.tc = t; v.q = qe; v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [2:0] q_pre;
        logic [2:0] exp_mask;
        logic       run;
        int         wrap_cnt;

        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
        rst8 = 1'b1; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; d8 = 3'd0;

        //  rst   en    up    load  d      tc    q      wrap
        // reset beats load and enable
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 4'd0,  1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 4'd0,  1'b0);
        // up count 12 cycles: 1..9,0,1,2 ; tc while q=9 ; wrap while q=0
        for (int i = 0; i < 12; i++) begin
            add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, (i == 9) ? 1'b1 : 1'b0,
                4'((i + 1) % 10), (i == 9) ? 1'b1 : 1'b0);
        end
        // load 0, then down wrap 0 -> 9, 8, 7
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd7,  1'b0);
        // loads: 5, 12 (out of range), 10 (= MODULUS), 9, then load vs en at q=9
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 4'd5,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 4'd0,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 4'd0,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9,  1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 4'd4,  1'b0);
        // hold at 3 then direction flip every cycle
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 4'd3,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0);
        // reset at q=9 with a pending up wrap: tc shows it, reset suppresses wrap
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9,  1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
            load = vecs[i].load; d = vecs[i].d;
            #1;
            chk("tc", i, 32'(tc), 32'(vecs[i].tc));
            @(posedge clk);
            #1;
            chk("q", i, 32'(q), 32'(vecs[i].q));
            chk("wrap", i, 32'(wrap), 32'(vecs[i].wrap));
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;

        // Full-range instance: up count 0..7,0 with J/K checked each cycle.
        rst8 = 1'b1; en8 = 1'b1; up8 = 1'b1;
        @(posedge clk);
        #1;
        chk("q8_reset", 0, 32'(q8), 32'd0);
        chk("wrap8_reset", 0, 32'(wrap8), 32'd0);
        rst8 = 1'b0;
        wrap_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            q_pre = 3'(c % 8);
            #1;
            chk("q8_pre", c, 32'(q8), 32'(q_pre));
            chk("tc8", c, 32'(tc8), (q_pre == 3'd7) ? 32'd1 : 32'd0);
            if (q_pre == 3'd7) begin
                // explicit wrap: clear every bit
                chk("j8", c, 32'(dut8.w_j), 32'd0);
                chk("k8", c, 32'(dut8.w_k), 32'd7);
            end else begin
                run = 1'b1;
                for (int b = 0; b < 3; b++) begin
                    exp_mask[b] = run;
                    run = run & q_pre[b];
                end
                chk("j8", c, 32'(dut8.w_j), 32'(exp_mask));
                chk("k8", c, 32'(dut8.w_k), 32'(exp_mask));
            end
            @(posedge clk);
            #1;
            chk("q8", c, 32'(q8), 32'(3'(q_pre + 3'd1)));
            chk("wrap8", c, 32'(wrap8), (q_pre == 3'd7) ? 32'd1 : 32'd0);
            if (wrap8 === 1'b1) begin
                wrap_cnt++;
            end
        end
        chk("wrap8_count", 0, 32'(wrap_cnt), 32'd1);
        en8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
